// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle: decode slot fields, forwarding sources, and the
// execute-side operands and control produced by the ID/EX register.
interface id_ex_stage_if #(parameter int CNT_W = 16) ();
    logic             id_valid;
    logic [31:0]      id_pc;
    logic [31:0]      id_rs1_data;
    logic [31:0]      id_rs2_data;
    logic [31:0]      id_imm;
    logic [4:0]       id_rs1_addr;
    logic [4:0]       id_rs2_addr;
    logic [4:0]       id_rd_addr;
    logic [3:0]       id_alu_sel;
    logic             id_asel;
    logic             id_bsel;
    logic             id_reg_wen;
    logic             id_mem_read;
    logic             id_mem_write;
    logic [1:0]       id_wb_sel;
    logic             flush;
    logic             exm_reg_wen;
    logic             exm_mem_read;
    logic [4:0]       exm_rd_addr;
    logic [31:0]      exm_alu_out;
    logic             mwb_reg_wen;
    logic [4:0]       mwb_rd_addr;
    logic [31:0]      mwb_wdata;
    logic             stall;
    logic [31:0]      ex_a_in;
    logic [31:0]      ex_b_in;
    logic [3:0]       ex_alu_sel;
    logic [31:0]      ex_store_data;
    logic [31:0]      ex_pc;
    logic [4:0]       ex_rd_addr;
    logic             ex_valid;
    logic             ex_reg_wen;
    logic             ex_mem_read;
    logic             ex_mem_write;
    logic [1:0]       ex_wb_sel;
    logic [CNT_W-1:0] bubble_cnt;

    modport master (
        output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_sel, id_asel, id_bsel,
               id_reg_wen, id_mem_read, id_mem_write, id_wb_sel, flush,
               exm_reg_wen, exm_mem_read, exm_rd_addr, exm_alu_out,
               mwb_reg_wen, mwb_rd_addr, mwb_wdata,
        input  stall, ex_a_in, ex_b_in, ex_alu_sel, ex_store_data, ex_pc, ex_rd_addr,
               ex_valid, ex_reg_wen, ex_mem_read, ex_mem_write, ex_wb_sel, bubble_cnt
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_sel, id_asel, id_bsel,
               id_reg_wen, id_mem_read, id_mem_write, id_wb_sel, flush,
               exm_reg_wen, exm_mem_read, exm_rd_addr, exm_alu_out,
               mwb_reg_wen, mwb_rd_addr, mwb_wdata,
        output stall, ex_a_in, ex_b_in, ex_alu_sel, ex_store_data, ex_pc, ex_rd_addr,
               ex_valid, ex_reg_wen, ex_mem_read, ex_mem_write, ex_wb_sel, bubble_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// EX/MEM and MEM/WB operand forwarding, and a saturating bubble counter.
module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    id_ex_stage_if.slave  bus
);

    logic             r_valid;
    logic [31:0]      r_pc;
    logic [31:0]      r_rs1_data;
    logic [31:0]      r_rs2_data;
    logic [31:0]      r_imm;
    logic [4:0]       r_rs1_addr;
    logic [4:0]       r_rs2_addr;
    logic [4:0]       r_rd_addr;
    logic [3:0]       r_alu_sel;
    logic             r_asel;
    logic             r_bsel;
    logic             r_reg_wen;
    logic             r_mem_read;
    logic             r_mem_write;
    logic [1:0]       r_wb_sel;
    logic [CNT_W-1:0] r_bubble_cnt;

    logic             w_hazard;
    logic             w_stall;
    logic             w_bubble;
    logic [31:0]      w_fwd_rs1;
    logic [31:0]      w_fwd_rs2;

    // EX/MEM beats MEM/WB; a load in EX/MEM has no data yet, and x0 is never forwarded.
    function automatic logic [31:0] fwd_sel(
        input logic [4:0]  idx,
        input logic [31:0] reg_val,
        input logic        exm_wen,
        input logic        exm_rd_mem,
        input logic [4:0]  exm_rd,
        input logic [31:0] exm_val,
        input logic        mwb_wen,
        input logic [4:0]  mwb_rd,
        input logic [31:0] mwb_val
    );
        logic [31:0] res;
        if (idx == 5'd0) begin
            res = reg_val;
        end else if (exm_wen && !exm_rd_mem && (exm_rd == idx)) begin
            res = exm_val;
        end else if (mwb_wen && (mwb_rd == idx)) begin
            res = mwb_val;
        end else begin
            res = reg_val;
        end
        return res;
    endfunction

    // Load-use hazard detection and bubble selection; flush suppresses the stall.
    always_comb begin
        w_hazard = bus.id_valid & r_valid & r_mem_read & (r_rd_addr != 5'd0) &
                   ((r_rd_addr == bus.id_rs1_addr) | (r_rd_addr == bus.id_rs2_addr));
        w_stall  = w_hazard & ~bus.flush;
        w_bubble = w_stall | bus.flush | ~bus.id_valid;
    end

    // Operand forwarding for both sources.
    always_comb begin
        w_fwd_rs1 = fwd_sel(r_rs1_addr, r_rs1_data, bus.exm_reg_wen, bus.exm_mem_read,
                            bus.exm_rd_addr, bus.exm_alu_out, bus.mwb_reg_wen,
                            bus.mwb_rd_addr, bus.mwb_wdata);
        w_fwd_rs2 = fwd_sel(r_rs2_addr, r_rs2_data, bus.exm_reg_wen, bus.exm_mem_read,
                            bus.exm_rd_addr, bus.exm_alu_out, bus.mwb_reg_wen,
                            bus.mwb_rd_addr, bus.mwb_wdata);
    end

    // ID/EX register: data always captured, control zeroed when a bubble loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_pc        <= 32'd0;
            r_rs1_data  <= 32'd0;
            r_rs2_data  <= 32'd0;
            r_imm       <= 32'd0;
            r_rs1_addr  <= 5'd0;
            r_rs2_addr  <= 5'd0;
            r_rd_addr   <= 5'd0;
            r_asel      <= 1'b0;
            r_bsel      <= 1'b0;
            r_alu_sel   <= 4'd0;
            r_reg_wen   <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_wb_sel    <= 2'd0;
        end else begin
            r_pc        <= bus.id_pc;
            r_rs1_data  <= bus.id_rs1_data;
            r_rs2_data  <= bus.id_rs2_data;
            r_imm       <= bus.id_imm;
            r_rs1_addr  <= bus.id_rs1_addr;
            r_rs2_addr  <= bus.id_rs2_addr;
            r_rd_addr   <= bus.id_rd_addr;
            r_asel      <= bus.id_asel;
            r_bsel      <= bus.id_bsel;
            if (w_bubble) begin
                r_valid     <= 1'b0;
                r_alu_sel   <= 4'd0;
                r_reg_wen   <= 1'b0;
                r_mem_read  <= 1'b0;
                r_mem_write <= 1'b0;
                r_wb_sel    <= 2'd0;
            end else begin
                r_valid     <= 1'b1;
                r_alu_sel   <= bus.id_alu_sel;
                r_reg_wen   <= bus.id_reg_wen;
                r_mem_read  <= bus.id_mem_read;
                r_mem_write <= bus.id_mem_write;
                r_wb_sel    <= bus.id_wb_sel;
            end
        end
    end

    // Saturating count of stall-induced bubbles only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bubble_cnt <= {CNT_W{1'b0}};
        end else if (w_stall && (r_bubble_cnt != {CNT_W{1'b1}})) begin
            r_bubble_cnt <= r_bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_bubble_cnt <= r_bubble_cnt;
        end
    end

    assign bus.stall         = w_stall;
    assign bus.ex_a_in       = r_asel ? r_pc  : w_fwd_rs1;
    assign bus.ex_b_in       = r_bsel ? r_imm : w_fwd_rs2;
    assign bus.ex_store_data = w_fwd_rs2;
    assign bus.ex_alu_sel    = r_alu_sel;
    assign bus.ex_pc         = r_pc;
    assign bus.ex_rd_addr    = r_rd_addr;
    assign bus.ex_valid      = r_valid;
    assign bus.ex_reg_wen    = r_reg_wen;
    assign bus.ex_mem_read   = r_mem_read;
    assign bus.ex_mem_write  = r_mem_write;
    assign bus.ex_wb_sel     = r_wb_sel;
    assign bus.bubble_cnt    = r_bubble_cnt;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the bubble counter.
REQ-002 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port id_valid  input  1  decode slot holds a real instruction.
REQ-005 SHALL have ports id_pc, id_rs1_data, id_rs2_data, id_imm  input  32 each  decode PC, register-file reads, and sign-extended immediate.
REQ-006 SHALL have ports id_rs1_addr, id_rs2_addr, id_rd_addr  input  5 each  source and destination register indices.
REQ-007 SHALL have ports id_alu_sel  input  4  ALU operation code; id_asel  input  1  A operand selects PC; id_bsel  input  1  B operand selects immediate.
REQ-008 SHALL have ports id_reg_wen, id_mem_read, id_mem_write  input  1 each; id_wb_sel  input  2  writeback source.
REQ-009 SHALL have port flush  input  1  discard the decode slot (taken branch or jump).
REQ-010 SHALL have ports exm_reg_wen, exm_mem_read  input  1 each; exm_rd_addr  input  5; exm_alu_out  input  32  EX/MEM forwarding source.
REQ-011 SHALL have ports mwb_reg_wen  input  1; mwb_rd_addr  input  5; mwb_wdata  input  32  MEM/WB forwarding source.
REQ-012 SHALL have port stall  output  1  hold PC and the IF/ID register.
REQ-013 SHALL have ports ex_a_in, ex_b_in  output  32 each  ALU operands; ex_alu_sel  output  4  ALU operation code.
REQ-014 SHALL have ports ex_store_data, ex_pc  output  32 each; ex_rd_addr  output  5; ex_valid, ex_reg_wen, ex_mem_read, ex_mem_write  output  1 each; ex_wb_sel  output  2.
REQ-015 SHALL have port bubble_cnt  output  CNT_W  count of inserted bubbles.

Function
REQ-016 SHALL register all id_* fields on a clk rising edge; registered values appear on the ex_* outputs one cycle later.
REQ-017 SHALL compute stall combinationally as id_valid & ex_valid & ex_mem_read & (ex_rd_addr != 0) & (ex_rd_addr == id_rs1_addr | ex_rd_addr == id_rs2_addr).
REQ-018 SHALL force stall to 0 whenever flush = 1.
REQ-019 SHALL load a bubble when stall = 1 or flush = 1; a bubble sets ex_valid, ex_reg_wen, ex_mem_read, ex_mem_write, ex_wb_sel and ex_alu_sel to 0 and leaves the data registers don't-care.
REQ-020 SHALL give flush priority over stall when both conditions hold in the same cycle.
REQ-021 SHALL resolve each forwarded source (rs1, rs2) combinationally from the registered source index r as follows:
- exm_alu_out if exm_reg_wen & !exm_mem_read & exm_rd_addr == r & r != 0;
- else mwb_wdata if mwb_reg_wen & mwb_rd_addr == r & r != 0;
- else the registered register-file value.
REQ-022 SHALL never forward to index x0; a source with index 0 always resolves to the registered value, which decode supplies as 0.
REQ-023 SHALL drive ex_a_in with the registered PC when the registered asel = 1, else with forwarded rs1.
REQ-024 SHALL drive ex_b_in with the registered immediate when the registered bsel = 1, else with forwarded rs2.
REQ-025 SHALL drive ex_store_data with forwarded rs2 regardless of bsel.
REQ-026 SHALL increment bubble_cnt once per cycle in which a stall-induced bubble loads, and SHALL saturate it at all-ones with no wrap.
REQ-027 SHALL NOT increment bubble_cnt on flush-only bubbles.
REQ-028 SHALL be fully occupied by an instruction with id_valid = 0 as a bubble, with all control fields zeroed as in REQ-019.

Reset
REQ-029 SHALL, on a clk edge with rst = 1, clear every registered field to 0, so that ex_valid = 0, all control outputs = 0, ex_a_in = ex_b_in = 0, and bubble_cnt = 0.
REQ-030 SHALL give rst priority over stall and flush.
REQ-031 SHALL, when rst is asserted mid-stall, discard the stalled instruction and keep stall = 0 while ex_valid = 0.

Verification
REQ-032 SHALL pass this case: EX/MEM writes x5 = 0x0000_00AA while ID reads rs1 = x5 with asel = 0 -> ex_a_in = 0x0000_00AA one cycle later.
REQ-033 SHALL pass this case: EX/MEM and MEM/WB both target x7 (0x11 vs 0x22) with rs2 = x7 and bsel = 0 -> ex_b_in = 0x11 (EX/MEM priority).
REQ-034 SHALL pass this case: a load to x3 sits in EX while ID reads rs1 = x3 -> stall = 1 for exactly one cycle, a bubble loads, bubble_cnt increments 0 -> 1, and the consumer later receives mwb_wdata.
REQ-035 SHALL pass this case: flush = 1 coinciding with a load-use hazard -> stall = 0, a bubble loads, and bubble_cnt is unchanged.
REQ-036 SHALL pass this case: MEM/WB writes x0 = 0xFFFF_FFFF with rs1 = x0 -> ex_a_in = 0.
REQ-037 SHALL pass this case: rst asserted during a stall, then released -> all outputs 0 and the next ID instruction is captured normally.
